muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit (RV32M) in the EX stage, beside the single-cycle ALU.
- The EX stage issues an operation with a one-cycle Start pulse.
- The unit answers on a Busy/Done handshake; the hazard unit stalls IF/ID/EX while Busy is high.
- The result is muxed onto the EX result path when Done is high.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/muldiv_unit.sv | 132 +++++++++++++
 tb/tb_muldiv_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared EX-stage definitions: RV32M operation codes, mul/div FSM states and latency.
package alu_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned MULDIV_LATENCY = XLEN + 2;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    function automatic logic is_mul(input muldiv_op_e op);
        return (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU});
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit; the multiply and divide steps
// share one accumulator and counter under a Busy/Done handshake.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3,
    parameter int CNT_WIDTH     = $clog2(DATA_WIDTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Start,
    input  logic                     Flush,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     Busy,
    output logic                     Done,
    output logic [DATA_WIDTH-1:0]    Result
);

    localparam int W = DATA_WIDTH;

    muldiv_state_e         state, state_nx;
    muldiv_op_e            op_in, op_q;
    logic                  neg_a, neg_b, div_zero, div_ovf;
    logic [W-1:0]          a_q, opd;
    logic [2*W-1:0]        acc;
    logic [CNT_WIDTH-1:0]  cnt;

    logic                  sgn_a_in, sgn_b_in;
    logic [W-1:0]          mag_a, mag_b;
    logic [W:0]            mul_sum, div_sh, div_df;
    logic [2*W-1:0]        mul_nx, div_nx, prod;
    logic [W-1:0]          quot, rem, fix_word;

    assign op_in    = muldiv_op_e'(Operation);
    assign sgn_a_in = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign sgn_b_in = (op_in inside {OP_MULH, OP_DIV, OP_REM});
    assign mag_a    = (sgn_a_in && SrcA[W-1]) ? -SrcA : SrcA;
    assign mag_b    = (sgn_b_in && SrcB[W-1]) ? -SrcB : SrcB;

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opd} : '0);
    assign mul_nx  = {mul_sum, acc[W-1:1]};

    // Divide: remainder in the high half, dividend/quotient bits in the low half.
    assign div_sh  = {acc[2*W-1:W], acc[W-1]};
    assign div_df  = div_sh - {1'b0, opd};
    assign div_nx  = div_df[W] ? {div_sh[W-1:0], acc[W-2:0], 1'b0}
                               : {div_df[W-1:0], acc[W-2:0], 1'b1};

    assign prod = (neg_a ^ neg_b) ? -acc : acc;
    assign quot = (neg_a ^ neg_b) ? -acc[W-1:0] : acc[W-1:0];
    assign rem  = neg_a ? -acc[2*W-1:W] : acc[2*W-1:W];

    always_comb begin
        fix_word = '0;
        case (op_q)
            OP_MUL:                        fix_word = prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_word = prod[2*W-1:W];
            OP_DIV, OP_DIVU:               fix_word = div_zero ? '1 : div_ovf ? {1'b1, {(W-1){1'b0}}} : quot;
            OP_REM, OP_REMU:               fix_word = div_zero ? a_q : div_ovf ? '0 : rem;
            default:                       fix_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            IDLE: if (Start) state_nx = CALC;
            CALC: begin
                Busy = 1'b1;
                if (cnt == CNT_WIDTH'(1)) state_nx = FIX;
            end
            FIX: begin
                Busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                Done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (Flush && state != IDLE) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_MUL;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            a_q      <= '0;
            opd      <= '0;
            acc      <= '0;
            cnt      <= '0;
            Result   <= '0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    op_q     <= op_in;
                    neg_a    <= sgn_a_in && SrcA[W-1];
                    neg_b    <= sgn_b_in && SrcB[W-1];
                    div_zero <= (SrcB == '0);
                    div_ovf  <= (op_in inside {OP_DIV, OP_REM}) &&
                                (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
                    a_q      <= SrcA;
                    opd      <= is_mul(op_in) ? mag_a : mag_b;
                    acc      <= {{W{1'b0}}, (is_mul(op_in) ? mag_b : mag_a)};
                    cnt      <= CNT_WIDTH'(W);
                end
                CALC: if (!Flush) begin
                    acc <= is_mul(op_q) ? mul_nx : div_nx;
                    cnt <= cnt - CNT_WIDTH'(1);
                end
                FIX: if (!Flush) Result <= fix_word;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic [2:0]  Operation = '0;
    logic        Busy, Done;
    logic [31:0] Result;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Flush(Flush),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issues one operation and waits (bounded) for Done; checks handshake timing and Result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int unsigned cyc, busy_cyc, unstable;
        logic [31:0] prev;
        @(negedge clk);
        prev = Result;
        Operation = op; SrcA = a; SrcB = b; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        cyc = 1; busy_cyc = 0; unstable = 0;
        while (!Done && cyc < 100) begin
            if (Busy) busy_cyc++;
            if (Result !== prev) unstable++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_done_cycle"}, 64'(cyc), 64'(MULDIV_LATENCY));
        check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(MULDIV_LATENCY - 1));
        check({tag, "_result_held"}, 64'(unstable), 64'd0);
        check({tag, "_busy_in_done"}, 64'(Busy), 64'd0);
        check({tag, "_result"}, 64'(Result), 64'(exp));
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(Done), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b, held;
        logic [2:0]  op;
        int unsigned seen_done, seen_busy;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_result", 64'(Result), 64'd0);
        @(negedge clk); reset = 1'b0;

        run_op("mul_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_op("div_by0_neg", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_by0_neg", 3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_muldiv(op, a, b));
        end

        // Flush mid-CALC, with a competing Start in the same cycle
        held = Result;
        @(negedge clk);
        Operation = 3'd5; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        Flush = 1'b1; Start = 1'b1; Operation = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
        @(posedge clk); #1;
        Flush = 1'b0; Start = 1'b0;
        check("flush_busy_low", 64'(Busy), 64'd0);
        check("flush_result_kept", 64'(Result), 64'(held));
        seen_done = 0; seen_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (Done) seen_done++;
            if (Busy) seen_busy++;
        end
        check("flush_no_done", 64'(seen_done), 64'd0);
        check("flush_start_ignored", 64'(seen_busy), 64'd0);
        check("flush_result_still", 64'(Result), 64'(held));
        run_op("after_flush_divu", 3'd5, 32'd100, 32'd7, 32'd14);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        Operation = 3'd0; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("areset_busy", 64'(Busy), 64'd0);
        check("areset_done", 64'(Done), 64'd0);
        check("areset_result", 64'(Result), 64'd0);
        @(negedge clk); reset = 1'b0;
        run_op("after_reset_remu", 3'd7, 32'd100, 32'd7, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
